// File: rtl/call_stack.sv
// rtl/call_stack.sv - hardware return-address stack with sticky overflow/underflow flags
module call_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [AW-1:0]    push_addr,
   input  logic             flush,
   output logic [AW-1:0]    ret_addr,
   output logic             ret_valid,
   output logic [AW-1:0]    top_addr,
   output logic [PTR_W:0]   count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

   // Entry storage is deliberately not reset; sp alone decides what is valid.
   logic [AW-1:0]    mem [DEPTH];
   logic [PTR_W:0]   sp;
   logic [PTR_W:0]   sp_dec;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_idx;

   assign sp_dec  = sp - SP_ONE;
   assign top_idx = sp_dec[PTR_W-1:0];
   assign wr_idx  = sp[PTR_W-1:0];

   assign count    = sp;
   assign empty    = (sp == '0);
   assign full     = (sp == SP_FULL);
   assign top_addr = empty ? '0 : mem[top_idx];

   // Entry writes: a push+pop on a non-empty stack replaces the top in place.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         if (pop && !empty) begin
            mem[top_idx] <= push_addr;
         end else if (!full) begin
            mem[wr_idx] <= push_addr;
         end
      end
   end

   // Stack pointer, popped address register and sticky fault flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         ret_addr  <= '0;
         ret_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         sp        <= '0;
         ret_valid <= 1'b0;
      end else begin
         ret_valid <= 1'b0;
         if (pop && !empty) begin
            ret_addr  <= mem[top_idx];
            ret_valid <= 1'b1;
            if (!push) begin
               sp <= sp_dec;
            end
         end else if (pop) begin
            // A bad ret on an empty stack; any accompanying push still lands.
            underflow <= 1'b1;
            if (push) begin
               sp <= sp + SP_ONE;
            end
         end else if (push) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               sp <= sp + SP_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - scoreboard testbench for call_stack
module tb_call_stack;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic        pop;
   logic [31:0] push_addr;
   logic        flush;
   logic [31:0] ret_addr;
   logic        ret_valid;
   logic [31:0] top_addr;
   logic [3:0]  count;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q [$];

   call_stack #(.DEPTH(8), .AW(32)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
      .flush(flush), .ret_addr(ret_addr), .ret_valid(ret_valid),
      .top_addr(top_addr), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; inputs are changed #1 after the edge.
   task automatic step(input logic p, input logic q, input logic [31:0] a,
                       input logic f, input logic r);
      push = p; pop = q; push_addr = a; flush = f; rst = r;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; push_addr = '0; flush = 1'b0; rst = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] a);
      step(1'b1, 1'b0, a, 1'b0, 1'b0);
   endtask

   task automatic do_pop(input logic [31:0] exp);
      exp_q.push_back(exp);
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " ret_addr"},  ret_addr,  32'h0);
      chk({tag, " ret_valid"}, ret_valid, 32'h0);
      chk({tag, " count"},     count,     32'h0);
      chk({tag, " empty"},     empty,     32'h1);
      chk({tag, " full"},      full,      32'h0);
      chk({tag, " overflow"},  overflow,  32'h0);
      chk({tag, " underflow"}, underflow, 32'h0);
      chk({tag, " top_addr"},  top_addr,  32'h0);
   endtask

   // Monitor: every ret_valid pulse must match the next expected address.
   always @(negedge clk) begin
      if (ret_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL spurious_ret_valid: got ret_addr 0x%0h expected no pulse", ret_addr);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            if (ret_addr !== e) begin
               fails++;
               $display("FAIL ret_addr: got 0x%0h expected 0x%0h", ret_addr, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      push = 0; pop = 0; push_addr = 0; flush = 0; rst = 1;
      @(posedge clk); #1;
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk_reset_state("reset");

      // LIFO order, back-to-back pops
      do_push(32'h10); do_push(32'h20); do_push(32'h30);
      chk("lifo count", count, 32'd3);
      chk("lifo top", top_addr, 32'h30);
      do_pop(32'h30); do_pop(32'h20); do_pop(32'h10);
      chk("lifo empty", empty, 32'h1);
      chk("lifo overflow", overflow, 32'h0);
      chk("lifo underflow", underflow, 32'h0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("ret_valid pulse ends", ret_valid, 32'h0);
      chk("ret_addr holds", ret_addr, 32'h10);

      // Fill and overflow
      for (int i = 0; i < 8; i++) do_push(32'h100 + i);
      chk("fill full", full, 32'h1);
      chk("fill overflow clear", overflow, 32'h0);
      do_push(32'hDEAD);
      chk("ovf flag", overflow, 32'h1);
      chk("ovf count", count, 32'd8);
      chk("ovf top", top_addr, 32'h107);
      do_pop(32'h107);
      chk("ovf pop count", count, 32'd7);
      chk("ovf sticky", overflow, 32'h1);

      // Underflow on empty stack
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("flush count", count, 32'd0);
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      chk("udf flag", underflow, 32'h1);
      chk("udf ret_valid", ret_valid, 32'h0);
      chk("udf ret_addr held", ret_addr, 32'h107);
      chk("udf count", count, 32'd0);
      do_push(32'h55);
      do_pop(32'h55);
      chk("udf sticky", underflow, 32'h1);

      // Simultaneous push and pop replaces the top
      do_push(32'hA); do_push(32'hB);
      exp_q.push_back(32'hB);
      step(1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
      chk("pp count", count, 32'd2);
      chk("pp top", top_addr, 32'hC);
      do_pop(32'hC); do_pop(32'hA);
      chk("pp empty", empty, 32'h1);

      // Flush beats push, flags unchanged
      do_push(32'h1); do_push(32'h2); do_push(32'h3);
      step(1'b1, 1'b0, 32'h9, 1'b1, 1'b0);
      chk("flush2 count", count, 32'd0);
      chk("flush2 empty", empty, 32'h1);
      chk("flush2 overflow", overflow, 32'h1);
      chk("flush2 underflow", underflow, 32'h1);

      // Reset mid-sequence, with a push strobe present
      do_push(32'h4); do_push(32'h5);
      exp_q.push_back(32'h5);
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h6, 1'b0, 1'b1);
      chk_reset_state("midrst");

      // Push+pop on empty acts as push plus underflow
      step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
      chk("ppe count", count, 32'd1);
      chk("ppe top", top_addr, 32'h77);
      chk("ppe ret_valid", ret_valid, 32'h0);
      chk("ppe underflow", underflow, 32'h1);
      chk("ppe overflow", overflow, 32'h0);

      // Full stack push+pop: replace, no overflow
      for (int i = 0; i < 7; i++) do_push(32'h200 + i);
      chk("fpp full", full, 32'h1);
      exp_q.push_back(32'h206);
      step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
      chk("fpp overflow", overflow, 32'h0);
      chk("fpp top", top_addr, 32'h300);
      chk("fpp count", count, 32'd8);

      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("scoreboard drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
